// File: rtl/pipe_stage_chain.sv
// -----------------------------------------------------------------------------
// pipe_stage_chain
//
// Elastic chain of NUM_STAGES pipeline registers. It replaces a set of fixed
// IF/ID, ID/EX, EX/MEM and MEM/WB stage registers with one block. Stage 0 is
// the youngest stage and the oldest stage (NUM_STAGES-1) drives the output.
//
// Each stage carries its own valid bit. The chain provides:
//   - valid/ready backpressure at both ends,
//   - a stall that holds stages 0..stall_idx_i and inserts a bubble behind
//     the stall point,
//   - a flush that kills the youngest flush_depth_i stages,
//   - a registered occupancy count and a saturating count of flushed entries.
//
// Ports
//   clk_i          rising-edge clock
//   rst_i          asynchronous active-low reset
//   in_valid_i     upstream payload valid
//   in_data_i      upstream payload
//   in_ready_o     chain accepts in_data_i this cycle
//   out_valid_o    oldest stage presents a consumable payload
//   out_data_o     payload of the oldest stage
//   out_ready_i    downstream accepts the payload
//   stall_i        hold request
//   stall_idx_i    stall point: stages 0..stall_idx_i hold
//   flush_i        kill request
//   flush_depth_i  number of youngest stages to kill (clamped to NUM_STAGES)
//   stage_valid_o  per-stage valid bits
//   stage_data_o   flattened payloads; stage k at [k*DATA_W +: DATA_W]
//   count_o        registered number of valid stages
//   flush_cnt_o    saturating number of valid entries killed by flushes
// -----------------------------------------------------------------------------
module pipe_stage_chain #(
    parameter int NUM_STAGES = 4,
    parameter int DATA_W     = 32,
    parameter int IDX_W      = $clog2(NUM_STAGES + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         in_valid_i,
    input  logic [DATA_W-1:0]            in_data_i,
    output logic                         in_ready_o,
    output logic                         out_valid_o,
    output logic [DATA_W-1:0]            out_data_o,
    input  logic                         out_ready_i,
    input  logic                         stall_i,
    input  logic [IDX_W-1:0]             stall_idx_i,
    input  logic                         flush_i,
    input  logic [IDX_W-1:0]             flush_depth_i,
    output logic [NUM_STAGES-1:0]        stage_valid_o,
    output logic [NUM_STAGES*DATA_W-1:0] stage_data_o,
    output logic [IDX_W-1:0]             count_o,
    output logic [15:0]                  flush_cnt_o
);

    // Up to NUM_STAGES killed stages plus the entry moving into stage d.
    localparam int KILL_W = $clog2(NUM_STAGES + 2);

    logic [NUM_STAGES-1:0] valid_q, valid_d;
    logic [DATA_W-1:0]     data_q [NUM_STAGES];
    logic [DATA_W-1:0]     data_d [NUM_STAGES];
    logic [IDX_W-1:0]      count_q, count_d;
    logic [15:0]           flush_cnt_q, flush_cnt_d;

    logic [NUM_STAGES-1:0] hold;
    logic [NUM_STAGES-1:0] free;
    int                    flush_d;
    logic [KILL_W-1:0]     kill_cnt;
    logic [16:0]           flush_sum;

    // -------------------------------------------------------------------------
    // Hold / free chain and effective flush depth.
    // free[k] means stage k may take new contents this cycle: it is not held
    // and its current occupant is either empty or leaving. The chain resolves
    // from the oldest stage towards the youngest.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        hold    = '0;
        free    = '0;
        flush_d = 0;

        for (int k = 0; k < NUM_STAGES; k++) begin
            hold[k] = stall_i && (k <= int'(stall_idx_i));
        end

        free[NUM_STAGES-1] = !hold[NUM_STAGES-1]
                             && (!valid_q[NUM_STAGES-1] || out_ready_i);
        for (int k = NUM_STAGES - 2; k >= 0; k--) begin
            free[k] = !hold[k] && (!valid_q[k] || free[k+1]);
        end

        if (flush_i) begin
            flush_d = (int'(flush_depth_i) > NUM_STAGES) ? NUM_STAGES
                                                         : int'(flush_depth_i);
        end
    end

    // -------------------------------------------------------------------------
    // Next-state: shift, bubble insertion, flush override, statistics.
    // -------------------------------------------------------------------------
    always_comb begin
        valid_d  = valid_q;
        kill_cnt = '0;
        count_d  = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            data_d[k] = data_q[k];
        end

        // Stage 0 samples the input; an idle input loads a clean bubble.
        if (free[0]) begin
            valid_d[0] = in_valid_i;
            data_d[0]  = in_valid_i ? in_data_i : '0;
        end

        // A free stage takes its younger neighbour only when that neighbour is
        // itself advancing; a held neighbour leaves a bubble behind the stall.
        for (int k = 1; k < NUM_STAGES; k++) begin
            if (free[k]) begin
                if (free[k-1]) begin
                    valid_d[k] = valid_q[k-1];
                    data_d[k]  = data_q[k-1];
                end else begin
                    valid_d[k] = 1'b0;
                    data_d[k]  = '0;
                end
            end
        end

        // Flush overrides hold and load for the youngest flush_d stages.
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (k < flush_d) begin
                kill_cnt   = kill_cnt + KILL_W'(valid_q[k]);
                valid_d[k] = 1'b0;
                data_d[k]  = '0;
            end
        end

        // The entry leaving the killed region into stage flush_d is wrong-path
        // too, so it arrives as a bubble and is counted as killed.
        for (int k = 1; k < NUM_STAGES; k++) begin
            if (k == flush_d && free[k] && free[k-1]) begin
                kill_cnt   = kill_cnt + KILL_W'(valid_q[k-1]);
                valid_d[k] = 1'b0;
                data_d[k]  = '0;
            end
        end

        for (int k = 0; k < NUM_STAGES; k++) begin
            count_d = count_d + IDX_W'(valid_d[k]);
        end

        flush_sum   = {1'b0, flush_cnt_q} + 17'(kill_cnt);
        flush_cnt_d = flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
    end

    // -------------------------------------------------------------------------
    // State registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q     <= '0;
            count_q     <= '0;
            flush_cnt_q <= '0;
            // NOTE: the payload array is reset as well so that bubbles always
            // read as zero on stage_data_o, including straight after reset.
            for (int k = 0; k < NUM_STAGES; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every stage samples the
            // pre-edge value of its neighbour and the shift is race-free.
            valid_q     <= valid_d;
            count_q     <= count_d;
            flush_cnt_q <= flush_cnt_d;
            for (int k = 0; k < NUM_STAGES; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs.
    // -------------------------------------------------------------------------
    // A flush with non-zero depth always clears stage 0, so input is taken
    // (and dropped) even when the chain is otherwise blocked.
    assign in_ready_o    = free[0] || (flush_i && (flush_depth_i != '0));
    assign out_valid_o   = valid_q[NUM_STAGES-1] && !hold[NUM_STAGES-1];
    assign out_data_o    = data_q[NUM_STAGES-1];
    assign stage_valid_o = valid_q;
    assign count_o       = count_q;
    assign flush_cnt_o   = flush_cnt_q;

    always_comb begin
        stage_data_o = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            stage_data_o[k*DATA_W +: DATA_W] = data_q[k];
        end
    end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_chain
//
// Self-checking bench for pipe_stage_chain (NUM_STAGES=4, DATA_W=32).
// A behavioural model of the stage array is stepped on each rising edge from
// the same inputs as the DUT; directed scenarios add fixed expectations.
// -----------------------------------------------------------------------------
module tb_pipe_stage_chain;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int IW = $clog2(N + 1);

    logic            clk_i         = 1'b0;
    logic            rst_i         = 1'b0;
    logic            in_valid_i    = 1'b0;
    logic [W-1:0]    in_data_i     = '0;
    logic            in_ready_o;
    logic            out_valid_o;
    logic [W-1:0]    out_data_o;
    logic            out_ready_i   = 1'b0;
    logic            stall_i       = 1'b0;
    logic [IW-1:0]   stall_idx_i   = '0;
    logic            flush_i       = 1'b0;
    logic [IW-1:0]   flush_depth_i = '0;
    logic [N-1:0]    stage_valid_o;
    logic [N*W-1:0]  stage_data_o;
    logic [IW-1:0]   count_o;
    logic [15:0]     flush_cnt_o;

    always #5 clk_i = ~clk_i;

    pipe_stage_chain #(
        .NUM_STAGES (N),
        .DATA_W     (W),
        .IDX_W      (IW)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .in_valid_i    (in_valid_i),
        .in_data_i     (in_data_i),
        .in_ready_o    (in_ready_o),
        .out_valid_o   (out_valid_o),
        .out_data_o    (out_data_o),
        .out_ready_i   (out_ready_i),
        .stall_i       (stall_i),
        .stall_idx_i   (stall_idx_i),
        .flush_i       (flush_i),
        .flush_depth_i (flush_depth_i),
        .stage_valid_o (stage_valid_o),
        .stage_data_o  (stage_data_o),
        .count_o       (count_o),
        .flush_cnt_o   (flush_cnt_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: one slot per stage, stepped from the stage rules.
    // ------------------------------------------------------------------------
    bit           m_v    [N];
    logic [W-1:0] m_d    [N];
    bit           m_free [N];
    bit           m_hold [N];
    int           m_fcnt;

    logic         obs_ir;
    logic         obs_ov;
    logic [W-1:0] obs_od;

    function automatic void m_reset();
        for (int k = 0; k < N; k++) begin
            m_v[k] = 1'b0;
            m_d[k] = '0;
        end
        m_fcnt = 0;
    endfunction

    function automatic void m_eval();
        for (int k = 0; k < N; k++) begin
            m_hold[k] = stall_i && (k <= int'(stall_idx_i));
        end
        for (int k = N - 1; k >= 0; k--) begin
            bit leaving;
            if (k == N - 1) leaving = out_ready_i;
            else            leaving = m_free[k+1];
            m_free[k] = !m_hold[k] && (!m_v[k] || leaving);
        end
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int k = 0; k < N; k++) c += int'(m_v[k]);
        return c;
    endfunction

    function automatic void m_step();
        bit           nv [N];
        logic [W-1:0] nd [N];
        int           d;
        int           killed;
        m_eval();
        d = 0;
        if (flush_i) d = (int'(flush_depth_i) > N) ? N : int'(flush_depth_i);
        killed = 0;
        for (int k = 0; k < N; k++) begin
            if (!m_free[k]) begin
                nv[k] = m_v[k];
                nd[k] = m_d[k];
            end else if (k == 0) begin
                nv[k] = in_valid_i;
                nd[k] = in_valid_i ? in_data_i : '0;
            end else if (m_free[k-1]) begin
                nv[k] = m_v[k-1];
                nd[k] = m_d[k-1];
            end else begin
                nv[k] = 1'b0;
                nd[k] = '0;
            end
        end
        for (int k = 0; k < d; k++) begin
            killed += int'(m_v[k]);
            nv[k] = 1'b0;
            nd[k] = '0;
        end
        if (d > 0 && d < N) begin
            if (m_free[d] && m_free[d-1]) begin
                killed += int'(m_v[d-1]);
                nv[d] = 1'b0;
                nd[d] = '0;
            end
        end
        for (int k = 0; k < N; k++) begin
            m_v[k] = nv[k];
            m_d[k] = nd[k];
        end
        m_fcnt = (m_fcnt + killed > 65535) ? 65535 : m_fcnt + killed;
    endfunction

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic drive(input bit iv, input logic [W-1:0] id, input bit ordy,
                         input bit st, input int sidx, input bit fl, input int fd);
        in_valid_i    = iv;
        in_data_i     = id;
        out_ready_i   = ordy;
        stall_i       = st;
        stall_idx_i   = IW'(sidx);
        flush_i       = fl;
        flush_depth_i = IW'(fd);
    endtask

    task automatic check_state();
        for (int k = 0; k < N; k++) begin
            check($sformatf("stage%0d_valid", k), 64'(stage_valid_o[k]), 64'(m_v[k]));
            check($sformatf("stage%0d_data", k), 64'(stage_data_o[k*W +: W]), 64'(m_d[k]));
        end
        check("count", 64'(count_o), 64'(m_count()));
        check("flush_cnt", 64'(flush_cnt_o), 64'(m_fcnt));
    endtask

    // Called just after a rising edge with inputs already driven. Checks the
    // combinational outputs mid-cycle, then the registered state after the edge.
    task automatic run_cycle(input bit chk);
        #1;
        m_eval();
        obs_ir = in_ready_o;
        obs_ov = out_valid_o;
        obs_od = out_data_o;
        if (chk) begin
            check("in_ready", 64'(obs_ir),
                  64'(m_free[0] || (flush_i && (flush_depth_i != '0))));
            check("out_valid", 64'(obs_ov), 64'(m_v[N-1] && !m_hold[N-1]));
            if (m_v[N-1]) check("out_data", 64'(obs_od), 64'(m_d[N-1]));
        end
        @(posedge clk_i);
        m_step();
        #1;
        if (chk) check_state();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0, 0, 1'b0, 0);
            run_cycle(1'b1);
        end
    endtask

    task automatic push(input logic [W-1:0] data, input bit ordy);
        drive(1'b1, data, ordy, 1'b0, 0, 1'b0, 0);
        run_cycle(1'b1);
    endtask

    // Pulse reset between edges; returns 8 time units after a rising edge.
    task automatic mid_cycle_reset();
        #3;
        rst_i = 1'b0;
        m_reset();
        #1;
        check("rst_stage_valid", 64'(stage_valid_o), 64'(0));
        check("rst_count", 64'(count_o), 64'(0));
        check("rst_out_valid", 64'(out_valid_o), 64'(0));
        check("rst_flush_cnt", 64'(flush_cnt_o), 64'(0));
        #3;
        rst_i = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------------
    bit           s_ov [10];
    logic [W-1:0] s_od [10];
    int           peak;

    initial begin
        m_reset();
        drive(1'b0, '0, 1'b1, 1'b0, 0, 1'b0, 0);
        #12;
        check("reset_stage_valid", 64'(stage_valid_o), 64'(0));
        check("reset_stage_data", 64'(stage_data_o[63:0]), 64'(0));
        check("reset_count", 64'(count_o), 64'(0));
        check("reset_flush_cnt", 64'(flush_cnt_o), 64'(0));
        check("reset_out_valid", 64'(out_valid_o), 64'(0));
        check("reset_in_ready", 64'(in_ready_o), 64'(1));
        #9;
        rst_i = 1'b1;

        // Streaming: 0x11, 0x22, 0x33 back to back, downstream always ready.
        peak = 0;
        for (int c = 0; c < 10; c++) begin
            if (c < 3) drive(1'b1, W'(32'h11 * (c + 1)), 1'b1, 1'b0, 0, 1'b0, 0);
            else       drive(1'b0, '0, 1'b1, 1'b0, 0, 1'b0, 0);
            run_cycle(1'b1);
            s_ov[c] = obs_ov;
            s_od[c] = obs_od;
            if (int'(count_o) > peak) peak = int'(count_o);
        end
        check("stream_early_valid", 64'(s_ov[3]), 64'(0));
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stream_valid%0d", i), 64'(s_ov[4+i]), 64'(1));
            check($sformatf("stream_data%0d", i), 64'(s_od[4+i]), 64'(32'h11 * (i + 1)));
        end
        check("stream_peak_count", 64'(peak), 64'(3));

        // Backpressure: full chain 0xA0..0xA3 (stage k holds 0xA0+k).
        for (int i = 0; i < N; i++) push(W'(32'hA3 - i), 1'b0);
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 32'hEE, 1'b0, 1'b0, 0, 1'b0, 0);
            run_cycle(1'b1);
            check("bp_in_ready", 64'(obs_ir), 64'(0));
            for (int k = 0; k < N; k++) begin
                check($sformatf("bp_stage%0d", k), 64'(stage_data_o[k*W +: W]),
                      64'(32'hA0 + k));
            end
            check("bp_count", 64'(count_o), 64'(4));
        end
        drive(1'b0, '0, 1'b1, 1'b0, 0, 1'b0, 0);
        run_cycle(1'b1);
        check("bp_release_valid", 64'(obs_ov), 64'(1));
        check("bp_release_data", 64'(obs_od), 64'(32'hA3));
        idle(4);

        // Stall at stage 1 with stages holding 0x4,0x3,0x2,0x1 (stage 0 first).
        for (int i = 1; i <= N; i++) push(W'(i), 1'b0);
        drive(1'b1, 32'h5, 1'b1, 1'b1, 1, 1'b0, 0);
        run_cycle(1'b1);
        check("stall_in_ready", 64'(obs_ir), 64'(0));
        check("stall_exit_data", 64'(obs_od), 64'(1));
        check("stall_valid_bits", 64'(stage_valid_o), 64'(4'b1011));
        check("stall_stage0", 64'(stage_data_o[0*W +: W]), 64'(4));
        check("stall_stage1", 64'(stage_data_o[1*W +: W]), 64'(3));
        check("stall_stage2", 64'(stage_data_o[2*W +: W]), 64'(0));
        check("stall_stage3", 64'(stage_data_o[3*W +: W]), 64'(2));
        idle(5);

        // Partial flush of depth 2 on a full chain with input offered.
        for (int i = 0; i < N; i++) push(W'(32'hB0 + i), 1'b0);
        drive(1'b1, 32'hDD, 1'b1, 1'b0, 0, 1'b1, 2);
        run_cycle(1'b1);
        check("flush2_valid_bits", 64'(stage_valid_o), 64'(4'b1000));
        check("flush2_cnt", 64'(flush_cnt_o), 64'(3));
        check("flush2_count", 64'(count_o), 64'(1));
        idle(4);

        // Full stall combined with full flush: flush wins.
        for (int i = 0; i < N; i++) push(W'(32'hC0 + i), 1'b0);
        drive(1'b0, '0, 1'b1, 1'b1, 3, 1'b1, 4);
        run_cycle(1'b1);
        check("flush4_out_valid", 64'(obs_ov), 64'(0));
        check("flush4_valid_bits", 64'(stage_valid_o), 64'(0));
        check("flush4_cnt", 64'(flush_cnt_o), 64'(7));
        idle(2);

        // Asynchronous reset with three entries in flight.
        for (int i = 0; i < 3; i++) push(W'(32'hD0 + i), 1'b0);
        mid_cycle_reset();
        push(32'h77, 1'b1);
        check("post_reset_accept", 64'(stage_valid_o), 64'(4'b0001));
        idle(5);

        // Randomised traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            drive(($urandom_range(0, 9) < 7), W'($urandom),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 6) == 0), int'($urandom_range(0, 7)),
                  ($urandom_range(0, 11) == 0), int'($urandom_range(0, 7)));
            run_cycle(1'b1);
        end
        idle(6);

        // Saturation: each load/flush pair kills one entry counted twice.
        mid_cycle_reset();
        for (int i = 0; i < 32767; i++) begin
            drive(1'b1, W'(i), 1'b1, 1'b0, 0, 1'b0, 0);
            run_cycle(1'b0);
            drive(1'b0, '0, 1'b1, 1'b0, 0, 1'b1, 1);
            run_cycle(1'b0);
        end
        check("sat_preload", 64'(flush_cnt_o), 64'(16'hFFFE));
        for (int i = 0; i < N; i++) push(W'(32'hE0 + i), 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0, 0, 1'b1, 4);
        run_cycle(1'b1);
        check("sat_reach", 64'(flush_cnt_o), 64'(16'hFFFF));
        for (int i = 0; i < 2; i++) push(W'(32'hF0 + i), 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0, 0, 1'b1, 7);
        run_cycle(1'b1);
        check("sat_hold", 64'(flush_cnt_o), 64'(16'hFFFF));
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
